// File: rtl/concat_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared concat_unit.
// One transaction in flight; a watchdog turns a missing result into an error response.
module concat_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b_i,
  output logic [DATA_WIDTH-1:0]           cu_data_a_o,
  output logic [DATA_WIDTH-1:0]           cu_data_b_o,
  output logic                            cu_valid_o,
  input  logic                            cu_ready_i,
  input  logic [2*DATA_WIDTH-1:0]         cu_data_out_i,
  input  logic                            cu_valid_out_i,
  output logic                            cu_ready_out_o,
  output logic                            resp_valid_o,
  input  logic                            resp_ready_i,
  output logic [2*DATA_WIDTH-1:0]         resp_data_o,
  output logic [ID_WIDTH-1:0]             resp_id_o,
  output logic                            resp_err_o,
  output logic [7:0]                      timeout_count_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]   NREQ_W  = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_q, rr_d;
  logic [DATA_WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic                    err_q, err_d;
  logic [7:0]              to_cnt_q, to_cnt_d;
  logic [WD_W-1:0]         wd_q, wd_d;

  logic                    grant_vld;
  logic [PTR_W-1:0]        grant;
  logic [PTR_W:0]          scan;
  logic                    wd_expired;

  // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!grant_vld && req_valid_i[scan[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = scan[PTR_W-1:0];
      end
    end
  end

  assign wd_expired = (wd_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    id_d         = id_q;
    data_d       = data_q;
    err_d        = err_q;
    to_cnt_d     = to_cnt_q;
    wd_d         = wd_q;
    req_ready_o  = '0;
    cu_valid_o   = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          req_ready_o[grant] = 1'b1;
          opa_d   = req_a_i[grant*DATA_WIDTH +: DATA_WIDTH];
          opb_d   = req_b_i[grant*DATA_WIDTH +: DATA_WIDTH];
          id_d    = ID_WIDTH'(grant);
          rr_d    = (grant == PTR_MAX) ? '0 : grant + 1'b1;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        // Dropping cu_valid on the expiry cycle keeps the unit from accepting an orphan.
        cu_valid_o = (state_q == ISSUE) && !wd_expired;
        if (state_q == WAIT && cu_valid_out_i) begin
          data_d  = cu_data_out_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_expired) begin
          data_d   = '0;
          err_d    = 1'b1;
          to_cnt_d = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
          state_d  = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
          if (state_q == ISSUE && cu_ready_i) state_d = WAIT;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      id_q     <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      id_q     <= id_d;
      data_q   <= data_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
      wd_q     <= wd_d;
    end
  end

  // Results outside WAIT are accepted and dropped so the unit never stalls.
  assign cu_ready_out_o  = cu_valid_out_i;
  assign cu_data_a_o     = opa_q;
  assign cu_data_b_o     = opb_q;
  assign resp_data_o     = data_q;
  assign resp_id_o       = id_q;
  assign resp_err_o      = err_q;
  assign timeout_count_o = to_cnt_q;

endmodule
